rd_sched_arbiter: RTL and testbench

- Shares the single cache SRAM read port among PORTNUM per-port output controllers.
- Each controller pulses a block-address request, optionally flagged as the packet's last block with a partial word count.
- The arbiter latches requests and grants round-robin.
- For the granted port it issues a burst of word reads, tags the returned data with the port, and then pulses that port's read-done.

---
 rtl/rd_sched_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/rd_sched_arbiter.sv | 154 +++++++++++++++
 tb/tb_rd_sched_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_sched_pkg.sv
// Shared types for the cache read scheduler: FSM states, derived widths and
// the per-port latched request record.
package rd_sched_pkg;

    // Reference widths of the per-port request record; the top-level
    // parameters must keep these defaults for the struct to line up.
    localparam int BLK_AW = 10;
    localparam int TIMES_W = 4;
    localparam int PORT_W = $clog2(16);
    localparam int WIDX_W = TIMES_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [BLK_AW-1:0]  blk_addr;
        logic               last;
        logic [TIMES_W-1:0] last_times;
    } rd_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: combinational scan starting at a registered pointer,
// pointer advanced past the serviced index on request.
module rr_arbiter #(
    parameter int N = 16,
    localparam int W = $clog2(N)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] req,
    input  logic         upd,
    input  logic [W-1:0] upd_idx,
    output logic         gnt_vld,
    output logic [W-1:0] gnt_idx
);

    logic [W-1:0] ptr;

    // Pointer moves to the index after the one just serviced, wrapping at N.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr <= '0;
        end else if (upd) begin
            ptr <= (upd_idx == W'(N - 1)) ? '0 : upd_idx + 1'b1;
        end
    end

    // First requester at or after the pointer, scanning modulo N.
    always_comb begin
        int k;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        k = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!gnt_vld && req[k]) begin
                gnt_vld = 1'b1;
                gnt_idx = W'(k);
            end
        end
    end

endmodule

// File: rtl/rd_sched_arbiter.sv
// Shares the cache SRAM read port among the per-port output controllers:
// latches block requests, grants round-robin, issues one word burst per
// grant, tags returned data with the owner port and pulses its read-done.
module rd_sched_arbiter
    import rd_sched_pkg::*;
#(
    parameter int PORTNUM        = 16,
    parameter int BLK_ADDR_WIDTH = 10,
    parameter int TIMES_WIDTH    = 4,
    parameter int WORDS_PER_BLK  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int RD_LAT         = 2
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [PORTNUM-1:0]                  i_req_vld,
    input  logic [PORTNUM*BLK_ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [PORTNUM-1:0]                  i_req_last,
    input  logic [PORTNUM*TIMES_WIDTH-1:0]      i_req_last_times,
    output logic                                o_mem_rd_en,
    output logic [BLK_ADDR_WIDTH+TIMES_WIDTH-1:0] o_mem_addr,
    input  logic [DATA_WIDTH-1:0]               i_mem_rd_data,
    output logic [DATA_WIDTH-1:0]               o_rd_data,
    output logic                                o_rd_data_vld,
    output logic [$clog2(PORTNUM)-1:0]          o_rd_port,
    output logic                                o_rd_last,
    output logic [PORTNUM-1:0]                  o_r_done,
    output logic                                o_proto_err
);

    state_t                   state, state_nxt;
    logic [PORTNUM-1:0]       pend;
    rd_req_t [PORTNUM-1:0]    req_q;
    rd_req_t                  cur;
    logic [PORT_W-1:0]        gnt;
    logic [PORT_W-1:0]        arb_idx;
    logic                     arb_vld;
    logic [WIDX_W-1:0]        widx;
    logic [WIDX_W-1:0]        nm1;
    logic                     rd_en;
    logic                     final_wd;
    logic                     is_done;
    logic                     err_q;

    // Read-tracking delay line; stage k holds what was issued k cycles ago.
    logic [RD_LAT:1]              vld_pipe;
    logic [RD_LAT:1]              last_pipe;
    logic [RD_LAT:1][PORT_W-1:0]  port_pipe;

    assign cur      = req_q[gnt];
    // A full block is WORDS_PER_BLK words; a last block carries count-1.
    assign nm1      = cur.last ? cur.last_times : WIDX_W'(WORDS_PER_BLK - 1);
    assign final_wd = (widx == nm1);
    assign rd_en    = (state == S_READ);
    assign is_done  = (state == S_DONE);

    rr_arbiter #(.N(PORTNUM)) u_rr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .req     (pend),
        .upd     (is_done),
        .upd_idx (gnt),
        .gnt_vld (arb_vld),
        .gnt_idx (arb_idx)
    );

    // Request capture: a pulse on a busy port is a protocol error, except on
    // the granted port in S_DONE where the new pulse beats the clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend  <= '0;
            req_q <= '0;
            err_q <= 1'b0;
        end else begin
            for (int p = 0; p < PORTNUM; p++) begin
                if (i_req_vld[p]) begin
                    if (pend[p] && !(is_done && gnt == PORT_W'(p))) begin
                        err_q <= 1'b1;
                    end else begin
                        pend[p]             <= 1'b1;
                        req_q[p].blk_addr   <= i_req_addr[p*BLK_ADDR_WIDTH +: BLK_ADDR_WIDTH];
                        req_q[p].last       <= i_req_last[p];
                        req_q[p].last_times <= i_req_last_times[p*TIMES_WIDTH +: TIMES_WIDTH];
                    end
                end else if (is_done && gnt == PORT_W'(p)) begin
                    pend[p] <= 1'b0;
                end
            end
        end
    end

    // State, grant latch and word index.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
            gnt   <= '0;
            widx  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && arb_vld) begin
                gnt  <= arb_idx;
                widx <= '0;
            end else if (rd_en) begin
                widx <= widx + 1'b1;
            end
        end
    end

    // Next-state: one burst at a time, drained fully before the done pulse.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (arb_vld) state_nxt = S_READ;
            S_READ:  if (final_wd) state_nxt = S_DRAIN;
            S_DRAIN: if (vld_pipe[RD_LAT] && last_pipe[RD_LAT]) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Delay line matching the SRAM read latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            port_pipe <= '0;
        end else begin
            for (int k = RD_LAT; k >= 2; k--) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                last_pipe[k] <= last_pipe[k-1];
                port_pipe[k] <= port_pipe[k-1];
            end
            vld_pipe[1]  <= rd_en;
            last_pipe[1] <= rd_en && final_wd;
            port_pipe[1] <= gnt;
        end
    end

    // Done pulse to the granted port.
    always_comb begin
        o_r_done = '0;
        if (is_done) o_r_done[gnt] = 1'b1;
    end

    assign o_mem_rd_en   = rd_en;
    assign o_mem_addr    = rd_en ? {cur.blk_addr, widx} : '0;
    assign o_rd_data_vld = vld_pipe[RD_LAT];
    assign o_rd_port     = port_pipe[RD_LAT];
    assign o_rd_last     = last_pipe[RD_LAT];
    // Data is forced to zero outside valid beats so reset leaves every output low.
    assign o_rd_data     = vld_pipe[RD_LAT] ? i_mem_rd_data : '0;
    assign o_proto_err   = err_q;

endmodule

// File: tb/tb_rd_sched_arbiter.sv
// Bench for rd_sched_arbiter: schedule-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_rd_sched_arbiter;

    localparam int L = 2;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic [15:0]   i_req_vld;
    logic [159:0]  i_req_addr;
    logic [15:0]   i_req_last;
    logic [63:0]   i_req_last_times;
    logic          o_mem_rd_en;
    logic [13:0]   o_mem_addr;
    logic [31:0]   i_mem_rd_data;
    logic [31:0]   o_rd_data;
    logic          o_rd_data_vld;
    logic [3:0]    o_rd_port;
    logic          o_rd_last;
    logic [15:0]   o_r_done;
    logic          o_proto_err;

    rd_sched_arbiter #(.RD_LAT(L)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_vld(i_req_vld), .i_req_addr(i_req_addr),
        .i_req_last(i_req_last), .i_req_last_times(i_req_last_times),
        .o_mem_rd_en(o_mem_rd_en), .o_mem_addr(o_mem_addr),
        .i_mem_rd_data(i_mem_rd_data), .o_rd_data(o_rd_data),
        .o_rd_data_vld(o_rd_data_vld), .o_rd_port(o_rd_port),
        .o_rd_last(o_rd_last), .o_r_done(o_r_done), .o_proto_err(o_proto_err)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic logic [31:0] memf(input logic [13:0] a);
        return {a, 4'hC, a} ^ 32'hA5A5_0000;
    endfunction

    // SRAM model with fixed read latency L.
    logic [L-1:0] en_q = '0;
    logic [13:0]  addr_q [L];
    always @(posedge i_clk) begin
        en_q[0]   <= o_mem_rd_en;
        addr_q[0] <= o_mem_addr;
        for (int k = 1; k < L; k++) begin
            en_q[k]   <= en_q[k-1];
            addr_q[k] <= addr_q[k-1];
        end
    end
    assign i_mem_rd_data = en_q[L-1] ? memf(addr_q[L-1]) : 32'hDEAD_BEEF;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        bit          en;
        logic [13:0] addr;
        bit          vld;
        int          port;
        bit          last;
        logic [31:0] data;
        bit          done;
        int          dport;
    } exp_t;

    exp_t        sched [int];
    bit          m_pend [16];
    logic [9:0]  m_addr [16];
    bit          m_last [16];
    logic [3:0]  m_lt   [16];
    int          m_rr = 0;
    int          m_cur = 0;
    int          m_free_at = 0;
    int          m_done_at = -1;
    bit          m_err = 0;

    function automatic exp_t get_e(input int c);
        exp_t t;
        t = '{default: 0};
        if (sched.exists(c)) t = sched[c];
        return t;
    endfunction

    function automatic bit any_pend();
        bit a = 0;
        for (int i = 0; i < 16; i++) a |= m_pend[i];
        return a;
    endfunction

    function automatic void model_reset();
        sched.delete();
        for (int i = 0; i < 16; i++) m_pend[i] = 0;
        m_rr = 0; m_cur = 0; m_free_at = 0; m_done_at = -1; m_err = 0;
    endfunction

    // Advance the model over the edge that ends cycle 'cyc'.
    function automatic void model_step();
        int   p;
        int   n;
        exp_t t;
        if (cyc >= m_free_at && any_pend()) begin
            p = -1;
            for (int i = 0; i < 16; i++)
                if (p < 0 && m_pend[(m_rr + i) % 16]) p = (m_rr + i) % 16;
            n = m_last[p] ? int'(m_lt[p]) + 1 : 16;
            for (int k = 0; k < n; k++) begin
                t = get_e(cyc + 1 + k);
                t.en = 1; t.addr = {m_addr[p], 4'(k)};
                sched[cyc + 1 + k] = t;
                t = get_e(cyc + 1 + k + L);
                t.vld = 1; t.port = p; t.last = (k == n - 1);
                t.data = memf({m_addr[p], 4'(k)});
                sched[cyc + 1 + k + L] = t;
            end
            m_done_at = cyc + n + L + 1;
            t = get_e(m_done_at);
            t.done = 1; t.dport = p;
            sched[m_done_at] = t;
            m_free_at = m_done_at + 1;
            m_cur = p;
        end
        if (cyc == m_done_at) begin
            m_pend[m_cur] = 0;
            m_rr = (m_cur + 1) % 16;
        end
        for (int q = 0; q < 16; q++) begin
            if (i_req_vld[q]) begin
                if (m_pend[q]) m_err = 1;
                else begin
                    m_pend[q] = 1;
                    m_addr[q] = i_req_addr[q*10 +: 10];
                    m_last[q] = i_req_last[q];
                    m_lt[q]   = i_req_last_times[q*4 +: 4];
                end
            end
        end
    endfunction

    // Event log for the literal checks.
    int   rd_cnt, last_cnt, first_rd_cyc, first_data_cyc, last_data_cyc, done_cyc;
    logic [13:0] first_rd_addr;
    int   done_q [$];

    task automatic clear_log();
        rd_cnt = 0; last_cnt = 0; first_rd_cyc = -1; first_data_cyc = -1;
        last_data_cyc = -1; done_cyc = -1; first_rd_addr = '0;
        done_q.delete();
    endtask

    // Compare process: DUT against the model on every cycle.
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rst_n) begin
            model_reset();
            chk("rst_rd_en", 32'(o_mem_rd_en), 0);
            chk("rst_addr", 32'(o_mem_addr), 0);
            chk("rst_vld", 32'(o_rd_data_vld), 0);
            chk("rst_data", o_rd_data, 0);
            chk("rst_port", 32'(o_rd_port), 0);
            chk("rst_last", 32'(o_rd_last), 0);
            chk("rst_done", 32'(o_r_done), 0);
            chk("rst_err", 32'(o_proto_err), 0);
        end else begin
            e = get_e(cyc);
            chk("rd_en", 32'(o_mem_rd_en), 32'(e.en));
            chk("mem_addr", 32'(o_mem_addr), 32'(e.addr));
            chk("rd_vld", 32'(o_rd_data_vld), 32'(e.vld));
            if (e.vld) begin
                chk("rd_port", 32'(o_rd_port), 32'(e.port));
                chk("rd_last", 32'(o_rd_last), 32'(e.last));
                chk("rd_data", o_rd_data, e.data);
            end
            chk("r_done", 32'(o_r_done), e.done ? (32'h1 << e.dport) : 32'h0);
            chk("proto_err", 32'(o_proto_err), 32'(m_err));
            if (o_mem_rd_en) begin
                if (rd_cnt == 0) begin first_rd_cyc = cyc; first_rd_addr = o_mem_addr; end
                rd_cnt++;
            end
            if (o_rd_data_vld && first_data_cyc < 0) first_data_cyc = cyc;
            if (o_rd_last) begin last_cnt++; last_data_cyc = cyc; end
            for (int i = 0; i < 16; i++)
                if (o_r_done[i]) begin done_q.push_back(i); done_cyc = cyc; end
            sched.delete(cyc);
            model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge i_clk); #1;
    endtask

    task automatic set_req(input int p, input logic [9:0] a, input bit last, input logic [3:0] lt);
        i_req_vld[p] = 1'b1;
        i_req_addr[p*10 +: 10] = a;
        i_req_last[p] = last;
        i_req_last_times[p*4 +: 4] = lt;
    endtask

    task automatic pulse(input int p, input logic [9:0] a, input bit last, input logic [3:0] lt);
        set_req(p, a, last, lt);
        tick();
        i_req_vld = '0;
    endtask

    task automatic wait_quiet(input int maxc);
        int n = 0;
        while ((any_pend() || cyc < m_free_at) && n < maxc) begin
            tick();
            n++;
        end
        if (n >= maxc) chk("wait_timeout", 1, 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        int c0;
        i_rst_n = 1'b0;
        i_req_vld = '0; i_req_addr = '0; i_req_last = '0; i_req_last_times = '0;
        repeat (3) tick();
        i_rst_n = 1'b1;
        tick();

        // Single full-block request on port 3.
        clear_log();
        c0 = cyc;
        pulse(3, 10'h155, 1'b0, 4'd0);
        wait_quiet(60);
        chk("t1_rd_count", 32'(rd_cnt), 16);
        chk("t1_first_rd", 32'(first_rd_cyc - c0), 2);
        chk("t1_first_addr", 32'(first_rd_addr), 32'h1550);
        chk("t1_first_data", 32'(first_data_cyc - c0), 4);
        chk("t1_last_data", 32'(last_data_cyc - c0), 19);
        chk("t1_done_cyc", 32'(done_cyc - c0), 20);
        chk("t1_done_port", 32'(done_q.size() == 1 ? done_q[0] : -1), 3);

        // Last-block word counts.
        clear_log();
        pulse(0, 10'h011, 1'b1, 4'd0);
        wait_quiet(40);
        chk("t2_lt0_reads", 32'(rd_cnt), 1);
        clear_log();
        pulse(0, 10'h022, 1'b1, 4'd15);
        wait_quiet(40);
        chk("t2_lt15_reads", 32'(rd_cnt), 16);
        clear_log();
        pulse(0, 10'h033, 1'b1, 4'd4);
        wait_quiet(40);
        chk("t2_lt4_reads", 32'(rd_cnt), 5);
        chk("t2_lt4_lastcnt", 32'(last_cnt), 1);
        chk("t2_lt4_lastcyc", 32'(last_data_cyc - first_rd_cyc), 4 + L);

        // Reset so the pointer starts at 0, then all ports at once.
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        tick();
        clear_log();
        for (int p = 0; p < 16; p++) set_req(p, 10'(10'h100 + p), 1'b1, 4'd1);
        tick();
        i_req_vld = '0;
        wait_quiet(400);
        chk("t3_wave1_count", 32'(done_q.size()), 16);
        for (int i = 0; i < 16; i++) chk("t3_wave1_order", 32'(done_q[i]), 32'(i));
        pulse(4, 10'h044, 1'b1, 4'd0);
        wait_quiet(40);
        clear_log();
        for (int p = 0; p < 16; p++) set_req(p, 10'(10'h200 + p), 1'b1, 4'd1);
        tick();
        i_req_vld = '0;
        wait_quiet(400);
        chk("t3_wave2_count", 32'(done_q.size()), 16);
        for (int i = 0; i < 16; i++) chk("t3_wave2_order", 32'(done_q[i]), 32'((5 + i) % 16));

        // Duplicate pulse on the port being serviced.
        clear_log();
        pulse(7, 10'h377, 1'b0, 4'd0);
        repeat (4) tick();
        pulse(7, 10'h3AA, 1'b0, 4'd0);
        wait_quiet(60);
        chk("t4_err", 32'(o_proto_err), 1);
        chk("t4_done_count", 32'(done_q.size()), 1);
        chk("t4_rd_count", 32'(rd_cnt), 16);

        // New pulse on the same edge as the done clear.
        clear_log();
        pulse(2, 10'h0A0, 1'b1, 4'd2);
        tick();
        begin
            int n = 0;
            while (cyc != m_done_at && n < 50) begin tick(); n++; end
            if (n >= 50) chk("t5_wait_timeout", 1, 0);
        end
        pulse(2, 10'h0B0, 1'b1, 4'd1);
        wait_quiet(60);
        chk("t5_done_count", 32'(done_q.size()), 2);
        chk("t5_done0_port", 32'(done_q[0]), 2);
        chk("t5_done1_port", 32'(done_q[1]), 2);
        chk("t5_rd_count", 32'(rd_cnt), 5);

        // Reset in the middle of a burst.
        clear_log();
        pulse(9, 10'h099, 1'b0, 4'd0);
        repeat (4) tick();
        chk("t6_mid_read", 32'(o_mem_rd_en), 1);
        i_rst_n = 1'b0;
        #1;
        chk("t6_async_rd_en", 32'(o_mem_rd_en), 0);
        chk("t6_async_err", 32'(o_proto_err), 0);
        repeat (2) tick();
        i_rst_n = 1'b1;
        tick();
        chk("t6_no_done", 32'(done_q.size()), 0);
        set_req(14, 10'h0EE, 1'b1, 4'd0);
        set_req(2, 10'h022, 1'b1, 4'd0);
        tick();
        i_req_vld = '0;
        wait_quiet(60);
        chk("t6_done_count", 32'(done_q.size()), 2);
        chk("t6_first_port", 32'(done_q[0]), 2);
        chk("t6_second_port", 32'(done_q[1]), 14);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
